// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: initiator for the subtractive GCD engine (start / two-beat load / done).
// Define GCD_FEEDER_TIMEOUT_EN to add a WAIT-state watchdog and the res_timeout output.
module gcd_operand_feeder #(
    parameter int W              = 16,
    parameter int TIMEOUT_CYCLES = 70000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [W-1:0] gcd_data,
    output logic         gcd_start,
    output logic         gcd_clr,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
`ifdef GCD_FEEDER_TIMEOUT_EN
    output logic         res_timeout,
`endif
    output logic         busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LDA,
        ST_LDB,
        ST_WAIT,
        ST_CAPT,
        ST_CLR
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] b_q, b_d;
    logic         op_ready_q, op_ready_d;
    logic [W-1:0] gcd_data_q, gcd_data_d;
    logic         gcd_start_q, gcd_start_d;
    logic         gcd_clr_q, gcd_clr_d;
    logic         res_valid_q, res_valid_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic         busy_q, busy_d;

`ifdef GCD_FEEDER_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_timeout_q, res_timeout_d;
`endif

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        op_ready_d  = op_ready_q;
        gcd_data_d  = gcd_data_q;
        gcd_start_d = 1'b0;
        gcd_clr_d   = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        busy_d      = 1'b1;
`ifdef GCD_FEEDER_TIMEOUT_EN
        cnt_d         = cnt_q;
        res_timeout_d = res_timeout_q;
`endif

        unique case (state_q)
            ST_CLR: begin
                state_d    = ST_IDLE;
                op_ready_d = 1'b1;
                busy_d     = 1'b0;
            end

            ST_IDLE: begin
                busy_d = 1'b0;
                if (res_valid_q) begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        op_ready_d  = 1'b1;
                    end
                end else if (op_valid && op_ready_q) begin
                    op_ready_d = 1'b0;
                    // A zero operand makes the answer the other operand; the engine is skipped.
                    if ((op_a == '0) || (op_b == '0)) begin
                        res_data_d  = op_a | op_b;
                        res_valid_d = 1'b1;
                    end else begin
                        b_d         = op_b;
                        gcd_data_d  = op_a;
                        gcd_start_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_LDA;
                    end
                end
            end

            ST_LDA: begin
                gcd_data_d = b_q;
                state_d    = ST_LDB;
            end

            ST_LDB: begin
                state_d = ST_WAIT;
`ifdef GCD_FEEDER_TIMEOUT_EN
                cnt_d = '0;
`endif
            end

            ST_WAIT: begin
                if (gcd_done) begin
                    res_data_d  = gcd_result;
                    res_valid_d = 1'b1;
                    state_d     = ST_CAPT;
                end
`ifdef GCD_FEEDER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    res_data_d    = '0;
                    res_valid_d   = 1'b1;
                    res_timeout_d = 1'b1;
                    state_d       = ST_CAPT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_CAPT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    gcd_clr_d   = 1'b1;
                    state_d     = ST_CLR;
`ifdef GCD_FEEDER_TIMEOUT_EN
                    res_timeout_d = 1'b0;
`endif
                end
            end

            default: begin
                gcd_clr_d = 1'b1;
                state_d   = ST_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLR;
            b_q         <= '0;
            op_ready_q  <= 1'b0;
            gcd_data_q  <= '0;
            gcd_start_q <= 1'b0;
            gcd_clr_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b1;
`ifdef GCD_FEEDER_TIMEOUT_EN
            cnt_q         <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            op_ready_q  <= op_ready_d;
            gcd_data_q  <= gcd_data_d;
            gcd_start_q <= gcd_start_d;
            gcd_clr_q   <= gcd_clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
`ifdef GCD_FEEDER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            res_timeout_q <= res_timeout_d;
`endif
        end
    end

    assign op_ready  = op_ready_q;
    assign gcd_data  = gcd_data_q;
    assign gcd_start = gcd_start_q;
    assign gcd_clr   = gcd_clr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;
`ifdef GCD_FEEDER_TIMEOUT_EN
    assign res_timeout = res_timeout_q;
`endif

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Scoreboard bench for gcd_operand_feeder: a behavioural subtractive engine drives the DUT,
// expected GCDs come from a Euclid reference and are popped by a monitor on each result handshake.
`timescale 1ns/1ps
module tb_gcd_operand_feeder;

    localparam int W = 16;
`ifdef GCD_FEEDER_TIMEOUT_EN
    localparam int TMO = 300;
`else
    localparam int TMO = 70000;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         byp;
        logic         tmo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         res_ready = 1'b0;
    logic         op_ready;
    logic [W-1:0] gcd_data;
    logic         gcd_start;
    logic         gcd_clr;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         busy;
`ifdef GCD_FEEDER_TIMEOUT_EN
    logic         res_timeout;
`endif

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_start = 0;
    int   n_start_exp = 0;
    int   ready_mode = 0;
    logic eng_stall = 1'b0;

    always #5 clk = ~clk;

    gcd_operand_feeder #(.W(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .gcd_data   (gcd_data),
        .gcd_start  (gcd_start),
        .gcd_clr    (gcd_clr),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
`ifdef GCD_FEEDER_TIMEOUT_EN
        .res_timeout(res_timeout),
`endif
        .busy       (busy)
    );

    // Subtractive engine: samples A with start, B on the next edge, then iterates until equal.
    logic [1:0]   eng_ph;
    logic [W-1:0] ea, eb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_ph     <= 2'd0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
            ea         <= '0;
            eb         <= '0;
        end else if (gcd_clr) begin
            eng_ph   <= 2'd0;
            gcd_done <= 1'b0;
        end else begin
            case (eng_ph)
                2'd0: if (gcd_start) begin ea <= gcd_data; eng_ph <= 2'd1; end
                2'd1: begin eb <= gcd_data; eng_ph <= 2'd2; end
                2'd2: if (!eng_stall) begin
                    if (ea == eb) begin
                        gcd_result <= ea;
                        gcd_done   <= 1'b1;
                        eng_ph     <= 2'd3;
                    end else if (ea > eb) begin
                        ea <= ea - eb;
                    end else begin
                        eb <= eb - ea;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return W'(p);
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gcd_clr"},   gcd_clr,   1);
        checkOutput({tag, "_gcd_start"}, gcd_start, 0);
        checkOutput({tag, "_gcd_data"},  gcd_data,  0);
        checkOutput({tag, "_op_ready"},  op_ready,  0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_res_data"},  res_data,  0);
        checkOutput({tag, "_busy"},      busy,      1);
`ifdef GCD_FEEDER_TIMEOUT_EN
        checkOutput({tag, "_res_timeout"}, res_timeout, 0);
`endif
    endtask

    // Offer one pair, wait for acceptance, and register the expected response.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic tmo);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        while (!op_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            checkOutput("accept_timeout", op_ready, 1);
            op_valid = 1'b0;
            return;
        end
        e.a   = a;
        e.b   = b;
        e.byp = (a == '0) || (b == '0);
        e.tmo = tmo;
        e.res = tmo ? '0 : ref_gcd(a, b);
        if (!e.byp) n_start_exp++;
        exp_q.push_back(e);
        @(negedge clk);
        op_valid = 1'b0;
        if (e.byp) begin
            checkOutput("bypass_valid", res_valid, 1);
            checkOutput("bypass_data", res_data, e.res);
        end else begin
            checkOutput("start_on_accept", gcd_start, 1);
        end
    endtask

    task automatic waitDrain(input string tag);
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || res_valid) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_drain"}, W'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: drives res_ready, checks load beats, held results, handshakes and the clear pulse.
    initial begin : monitor
        int           post_hs;
        logic         start_pend;
        logic [W-1:0] pend_b;
        logic         held;
        logic [W-1:0] held_data;
        exp_t         e;
        post_hs    = 0;
        start_pend = 1'b0;
        pend_b     = '0;
        held       = 1'b0;
        held_data  = '0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
            if (rst) begin
                post_hs    = 0;
                start_pend = 1'b0;
                held       = 1'b0;
            end else begin
                if (post_hs == 1) begin
                    checkOutput("clr_pulse", gcd_clr, 1);
                    checkOutput("busy_in_clr", busy, 1);
                    post_hs = 2;
                end else if (post_hs == 2) begin
                    checkOutput("clr_width", gcd_clr, 0);
                    checkOutput("ready_after_clr", op_ready, 1);
                    post_hs = 0;
                end else if (post_hs == 3) begin
                    checkOutput("bypass_no_clr", gcd_clr, 0);
                    checkOutput("ready_after_bypass", op_ready, 1);
                    post_hs = 0;
                end

                if (start_pend) begin
                    checkOutput("start_width", gcd_start, 0);
                    checkOutput("load_b", gcd_data, pend_b);
                    start_pend = 1'b0;
                end else if (gcd_start) begin
                    n_start++;
                    if (exp_q.size() == 0) begin
                        checkOutput("start_without_request", gcd_start, 0);
                    end else begin
                        checkOutput("load_a", gcd_data, exp_q[$].a);
                        pend_b     = exp_q[$].b;
                        start_pend = 1'b1;
                    end
                end

                if (res_valid) begin
                    checkOutput("ready_blocked", op_ready, 0);
                    if (held) checkOutput("held_data", res_data, held_data);
                    if (res_ready) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("unexpected_result", res_valid, 0);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("res_data", res_data, e.res);
`ifdef GCD_FEEDER_TIMEOUT_EN
                            checkOutput("res_timeout", res_timeout, e.tmo);
`endif
                            post_hs = e.byp ? 3 : 1;
                        end
                        held = 1'b0;
                    end else begin
                        held      = 1'b1;
                        held_data = res_data;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [W-1:0] ra, rb;
        int           waited;

        // Reset, then one clear cycle before the feeder opens for operands.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_clr", gcd_clr, 0);
        checkOutput("post_reset_ready", op_ready, 1);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_valid", res_valid, 0);

        $display("[TB] basic engine transaction");
        ready_mode = 0;
        applyStimulus(16'd48, 16'd18, 1'b0);
        waitDrain("basic");

        $display("[TB] bypass pairs");
        applyStimulus(16'd0, 16'd35, 1'b0);
        applyStimulus(16'd0, 16'd0, 1'b0);
        applyStimulus(16'd77, 16'd0, 1'b0);
        waitDrain("bypass");

        $display("[TB] held result backpressure");
        ready_mode = 2;
        applyStimulus(16'd48, 16'd18, 1'b0);
        waited = 0;
        while (!res_valid && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("held_appears", res_valid, 1);
        repeat (10) @(negedge clk);
        checkOutput("held_still_valid", res_valid, 1);
        ready_mode = 0;
        applyStimulus(16'd17, 16'd5, 1'b0);
        waitDrain("held");

        $display("[TB] reset during WAIT");
        eng_stall = 1'b1;
        applyStimulus(16'd21, 16'd14, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("busy_in_wait", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkResetValues("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        eng_stall = 1'b0;
        applyStimulus(16'd21, 16'd14, 1'b0);
        waitDrain("after_reset");

        $display("[TB] randomized pairs");
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
            rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
            applyStimulus(ra, rb, 1'b0);
        end
        ready_mode = 0;
        waitDrain("random");

`ifdef GCD_FEEDER_TIMEOUT_EN
        $display("[TB] engine stuck, watchdog result");
        eng_stall = 1'b1;
        applyStimulus(16'd9, 16'd6, 1'b1);
        waitDrain("timeout");
        eng_stall = 1'b0;
        applyStimulus(16'd9, 16'd6, 1'b0);
        waitDrain("timeout_recover");
`endif

        checkOutput("start_count", W'(n_start), W'(n_start_exp));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
